// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz raster constants and shared types for the VGA timing generator.
// Any other mode is obtained by overriding the generator's parameters.
package vga_timing_pkg;

    localparam int CNT_BITS = 10;
    localparam int Y_BITS   = 9;

    localparam int DEF_WIDTH   = 640;
    localparam int DEF_HEIGHT  = 480;
    localparam int DEF_H_FRONT = 16;
    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BACK  = 48;
    localparam int DEF_V_FRONT = 10;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BACK  = 33;

    localparam bit DEF_H_SYNC_POL = 1'b0;
    localparam bit DEF_V_SYNC_POL = 1'b0;

    localparam int DEF_H_TOTAL      = DEF_WIDTH + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL      = DEF_HEIGHT + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_H_SYNC_START = DEF_WIDTH + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_HEIGHT + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    typedef logic [CNT_BITS-1:0] cntT;

    typedef struct packed {
        logic              screenEnd;
        logic              active;
        logic              hSync;
        logic              vSync;
        cntT               x;
        logic [Y_BITS-1:0] y;
    } rasterOutT;

    function automatic int axisTotal(input int visible, input int front,
                                     input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the pixel colour mux.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic              screenEnd;
    logic              active;
    logic              hSync;
    logic              vSync;
    cntT               x;
    logic [Y_BITS-1:0] y;

    modport master (output screenEnd, active, hSync, vSync, x, y);
    modport slave  (input  screenEnd, active, hSync, vSync, x, y);
endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one raster axis; wrap flags the enabled cycle that returns to 0.
module vga_axis_counter #(
    parameter int TOTAL      = 800,
    parameter int WIDTH_BITS = 10
) (
    input  logic                  clk25,
    input  logic                  reset,
    input  logic                  en,
    output logic [WIDTH_BITS-1:0] cnt,
    output logic                  wrap
);
    localparam logic [WIDTH_BITS-1:0] LAST = WIDTH_BITS'(TOTAL - 1);
    localparam logic [WIDTH_BITS-1:0] ONE  = WIDTH_BITS'(1);

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + ONE;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: two chained axis counters plus a registered decode so that
// sync, active, coordinates and screenEnd all leave on the same clock edge.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter bit H_SYNC_POL = DEF_H_SYNC_POL,
    parameter bit V_SYNC_POL = DEF_V_SYNC_POL
) (
    input  logic             clk25,
    input  logic             reset,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = axisTotal(WIDTH, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axisTotal(HEIGHT, V_FRONT, V_SYNC, V_BACK);

    localparam cntT H_ACT  = cntT'(WIDTH);
    localparam cntT V_ACT  = cntT'(HEIGHT);
    localparam cntT V_LAST = cntT'(HEIGHT - 1);
    localparam cntT H_SS   = cntT'(WIDTH + H_FRONT);
    localparam cntT H_SE   = cntT'(WIDTH + H_FRONT + H_SYNC);
    localparam cntT V_SS   = cntT'(HEIGHT + V_FRONT);
    localparam cntT V_SE   = cntT'(HEIGHT + V_FRONT + V_SYNC);

    localparam rasterOutT OUT_RESET = '{
        screenEnd: 1'b0,
        active:    1'b0,
        hSync:     ~H_SYNC_POL,
        vSync:     ~V_SYNC_POL,
        x:         '0,
        y:         '0
    };

    cntT       hCnt;
    cntT       vCnt;
    logic      hWrap;
    // The vertical wrap has no consumer: frame boundaries are taken from the decode below.
    logic      unusedVWrap;
    rasterOutT outNext;
    rasterOutT outReg;

    vga_axis_counter #(.TOTAL(H_TOTAL), .WIDTH_BITS(CNT_BITS)) hAxis (
        .clk25 (clk25),
        .reset (reset),
        .en    (1'b1),
        .cnt   (hCnt),
        .wrap  (hWrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL), .WIDTH_BITS(CNT_BITS)) vAxis (
        .clk25 (clk25),
        .reset (reset),
        .en    (hWrap),
        .cnt   (vCnt),
        .wrap  (unusedVWrap)
    );

    always_comb begin
        outNext           = '0;
        outNext.active    = (hCnt < H_ACT) && (vCnt < V_ACT);
        outNext.hSync     = (hCnt >= H_SS && hCnt < H_SE) ? H_SYNC_POL : ~H_SYNC_POL;
        outNext.vSync     = (vCnt >= V_SS && vCnt < V_SE) ? V_SYNC_POL : ~V_SYNC_POL;
        // First blanking pixel after the last visible one: game logic gets the whole vblank.
        outNext.screenEnd = (hCnt == H_ACT) && (vCnt == V_LAST);
        if (outNext.active) begin
            outNext.x = hCnt;
            outNext.y = vCnt[Y_BITS-1:0];
        end
    end

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            outReg <= OUT_RESET;
        end else begin
            outReg <= outNext;
        end
    end

    assign vga.screenEnd = outReg.screenEnd;
    assign vga.active    = outReg.active;
    assign vga.hSync     = outReg.hSync;
    assign vga.vSync     = outReg.vSync;
    assign vga.x         = outReg.x;
    assign vga.y         = outReg.y;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a shrunken positive-sync instance,
// both compared every cycle against a raster model derived from elapsed time since reset release.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    // Small raster for frame-level checks: 28 x 19 = 532 cycles per frame.
    localparam int BW = 16, BH = 12, BHF = 3, BHS = 5, BHB = 4;
    localparam int BVF = 2, BVS = 2, BVB = 3;
    localparam int BHT = BW + BHF + BHS + BHB;
    localparam int BVT = BH + BVF + BVS + BVB;
    localparam int BFRAME = BHT * BVT;

    localparam logic [22:0] RST_A = {1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 9'd0};
    localparam logic [22:0] RST_B = {1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0};

    logic clk25 = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #20 clk25 = ~clk25;

    vga_timing_gen_if ifA ();
    vga_timing_gen_if ifB ();

    vga_timing_gen dutA (
        .clk25 (clk25),
        .reset (reset),
        .vga   (ifA)
    );

    vga_timing_gen #(
        .WIDTH(BW), .HEIGHT(BH), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) dutB (
        .clk25 (clk25),
        .reset (reset),
        .vga   (ifB)
    );

    // Expected outputs k edges after reset release, straight from the raster definition.
    function automatic logic [22:0] model(input int k, input int w, input int h, input int hf,
                                          input int hs, input int hb, input int vf, input int vs,
                                          input int vb, input bit hp, input bit vp);
        int ht, vt, p, col, row;
        logic act, hsy, vsy, se;
        ht  = w + hf + hs + hb;
        vt  = h + vf + vs + vb;
        p   = k % (ht * vt);
        col = p % ht;
        row = p / ht;
        act = (col < w) && (row < h);
        hsy = (col >= w + hf && col < w + hf + hs) ? hp : !hp;
        vsy = (row >= h + vf && row < h + vf + vs) ? vp : !vp;
        se  = (col == w) && (row == h - 1);
        return {se, act, hsy, vsy, act ? 10'(col) : 10'd0, act ? 9'(row) : 9'd0};
    endfunction

    function automatic logic [22:0] modelA(input int k);
        return model(k, DEF_WIDTH, DEF_HEIGHT, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK,
                     DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK, 1'b0, 1'b0);
    endfunction

    function automatic logic [22:0] modelB(input int k);
        return model(k, BW, BH, BHF, BHS, BHB, BVF, BVS, BVB, 1'b1, 1'b1);
    endfunction

    function automatic logic [22:0] obsA();
        return {ifA.screenEnd, ifA.active, ifA.hSync, ifA.vSync, ifA.x, ifA.y};
    endfunction

    function automatic logic [22:0] obsB();
        return {ifB.screenEnd, ifB.active, ifB.hSync, ifB.vSync, ifB.x, ifB.y};
    endfunction

    task automatic step();
        @(posedge clk25);
        #1;
    endtask

    // Holds reset for n edges checking reset values, then releases between edges.
    task automatic hold_reset(input int n);
        @(negedge clk25);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            total++;
            if (obsA() !== RST_A) begin
                bad++;
                $display("FAIL reset_hold_A edge %0d: got %h want %h", i, obsA(), RST_A);
            end
            total++;
            if (obsB() !== RST_B) begin
                bad++;
                $display("FAIL reset_hold_B edge %0d: got %h want %h", i, obsB(), RST_B);
            end
        end
        @(negedge clk25);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        hold_reset($urandom_range(3, 8));
        step();
        total++;
        if (obsA() !== {1'b0, 1'b1, 1'b1, 1'b1, 19'd0}) begin
            bad++;
            $display("FAIL first_edge_A: got %h want %h", obsA(), {1'b0, 1'b1, 1'b1, 1'b1, 19'd0});
        end
        total++;
        if (obsB() !== {1'b0, 1'b1, 1'b0, 1'b0, 19'd0}) begin
            bad++;
            $display("FAIL first_edge_B: got %h want %h", obsB(), {1'b0, 1'b1, 1'b0, 1'b0, 19'd0});
        end
    endtask

    task automatic test_line_timing();
        int n, fails, aStart, xZero, lastFall, hsStart, runs, falls, rises;
        logic pa, ph;
        n = 3 * DEF_H_TOTAL + $urandom_range(0, 50);
        fails = 0; aStart = 0; xZero = 0; lastFall = 0; hsStart = 0;
        runs = 0; falls = 0; rises = 0; pa = 1'b0; ph = 1'b1;
        hold_reset($urandom_range(2, 6));
        for (int c = 0; c < n && fails < 8; c++) begin
            step();
            total++;
            if (obsA() !== modelA(c)) begin
                bad++; fails++;
                $display("FAIL raster_A cycle %0d: got %h want %h", c, obsA(), modelA(c));
            end
            total++;
            if (obsB() !== modelB(c)) begin
                bad++; fails++;
                $display("FAIL raster_B cycle %0d: got %h want %h", c, obsB(), modelB(c));
            end
            if (ifA.active && !pa) aStart = c;
            if (!ifA.active && pa) begin
                runs++;
                total++;
                if (c - aStart != DEF_WIDTH) begin
                    bad++;
                    $display("FAIL active_run_len: got %0d want %0d", c - aStart, DEF_WIDTH);
                end
            end
            if (ifA.active && ifA.x == 10'd0) xZero = c;
            if (!ifA.hSync && ph) begin
                falls++;
                total++;
                if (c - xZero != DEF_H_SYNC_START) begin
                    bad++;
                    $display("FAIL hsync_start: got %0d want %0d", c - xZero, DEF_H_SYNC_START);
                end
                if (falls > 1) begin
                    total++;
                    if (c - lastFall != DEF_H_TOTAL) begin
                        bad++;
                        $display("FAIL hsync_period: got %0d want %0d", c - lastFall, DEF_H_TOTAL);
                    end
                end
                lastFall = c;
                hsStart = c;
            end
            if (ifA.hSync && !ph) begin
                rises++;
                total++;
                if (c - hsStart != DEF_H_SYNC) begin
                    bad++;
                    $display("FAIL hsync_width: got %0d want %0d", c - hsStart, DEF_H_SYNC);
                end
            end
            pa = ifA.active;
            ph = ifA.hSync;
        end
        total++;
        if (runs != 3 || falls != 3 || rises != 3) begin
            bad++;
            $display("FAIL line_event_count: got runs=%0d falls=%0d rises=%0d want 3 each",
                     runs, falls, rises);
        end
    endtask

    task automatic test_frame_timing();
        int n, fails, actCnt, seCnt, lastSe, frameStart, vsCnt, lastVs, vsStart;
        logic pv;
        n = 3 * BFRAME + $urandom_range(0, 60);
        fails = 0; actCnt = 0; seCnt = 0; lastSe = 0; frameStart = 0;
        vsCnt = 0; lastVs = 0; vsStart = 0; pv = 1'b0;
        hold_reset($urandom_range(2, 6));
        for (int c = 0; c < n && fails < 8; c++) begin
            step();
            total++;
            if (obsB() !== modelB(c)) begin
                bad++; fails++;
                $display("FAIL frame_raster_B cycle %0d: got %h want %h", c, obsB(), modelB(c));
            end
            if (ifB.active) actCnt++;
            if (ifB.active && ifB.x == 10'd0 && ifB.y == 9'd0) frameStart = c;
            if (c % BFRAME == BFRAME - 1) begin
                total++;
                if (actCnt != BW * BH) begin
                    bad++;
                    $display("FAIL active_per_frame: got %0d want %0d", actCnt, BW * BH);
                end
                actCnt = 0;
            end
            if (ifB.screenEnd) begin
                seCnt++;
                total++;
                if (ifB.active !== 1'b0) begin
                    bad++;
                    $display("FAIL screenend_active: got %b want 0", ifB.active);
                end
                total++;
                if (seCnt == 1 && c != (BH - 1) * BHT + BW) begin
                    bad++;
                    $display("FAIL screenend_first: got %0d want %0d", c, (BH - 1) * BHT + BW);
                end else if (seCnt > 1 && c - lastSe != BFRAME) begin
                    bad++;
                    $display("FAIL screenend_period: got %0d want %0d", c - lastSe, BFRAME);
                end
                lastSe = c;
            end
            if (ifB.vSync && !pv) begin
                vsCnt++;
                total++;
                if (c - frameStart != (BH + BVF) * BHT) begin
                    bad++;
                    $display("FAIL vsync_start: got %0d want %0d", c - frameStart, (BH + BVF) * BHT);
                end
                if (vsCnt > 1) begin
                    total++;
                    if (c - lastVs != BFRAME) begin
                        bad++;
                        $display("FAIL vsync_period: got %0d want %0d", c - lastVs, BFRAME);
                    end
                end
                lastVs = c;
                vsStart = c;
            end
            if (!ifB.vSync && pv) begin
                total++;
                if (c - vsStart != BVS * BHT) begin
                    bad++;
                    $display("FAIL vsync_width: got %0d want %0d", c - vsStart, BVS * BHT);
                end
            end
            pv = ifB.vSync;
        end
        total++;
        if (seCnt != 3 || vsCnt != 3) begin
            bad++;
            $display("FAIL frame_event_count: got se=%0d vs=%0d want 3 each", seCnt, vsCnt);
        end
    endtask

    task automatic test_mid_reset();
        int n, fails, seAt;
        n = $urandom_range(3 * BHT, 9 * BHT + BHT - 1);
        fails = 0; seAt = -1;
        hold_reset($urandom_range(2, 5));
        for (int c = 0; c < n && fails < 8; c++) begin
            step();
            total++;
            if (obsB() !== modelB(c)) begin
                bad++; fails++;
                $display("FAIL pre_reset_B cycle %0d: got %h want %h", c, obsB(), modelB(c));
            end
        end
        // Assert reset between edges: outputs must clear without waiting for a clock.
        @(posedge clk25);
        #7;
        reset = 1'b0;
        #1;
        total++;
        if (obsA() !== RST_A) begin
            bad++;
            $display("FAIL async_reset_A: got %h want %h", obsA(), RST_A);
        end
        total++;
        if (obsB() !== RST_B) begin
            bad++;
            $display("FAIL async_reset_B: got %h want %h", obsB(), RST_B);
        end
        hold_reset($urandom_range(1, 4));
        for (int c = 0; c < 2 * BFRAME && seAt < 0 && fails < 8; c++) begin
            step();
            total++;
            if (obsA() !== modelA(c)) begin
                bad++; fails++;
                $display("FAIL restart_A cycle %0d: got %h want %h", c, obsA(), modelA(c));
            end
            total++;
            if (obsB() !== modelB(c)) begin
                bad++; fails++;
                $display("FAIL restart_B cycle %0d: got %h want %h", c, obsB(), modelB(c));
            end
            if (ifB.screenEnd) seAt = c;
        end
        total++;
        if (seAt != (BH - 1) * BHT + BW) begin
            bad++;
            $display("FAIL restart_screenend: got %0d want %0d (-1 = no pulse)",
                     seAt, (BH - 1) * BHT + BW);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
